// File: rtl/g_hamming_decoder_pipe.sv
// Multi-lane SECDED Hamming decoder, 2-stage valid/ready pipe.
// Stage 1 registers codeword, syndrome, overall parity and corrEn.
// Stage 2 registers corrected outputs, flags and updates counters.
// In : clk, rst_n, inValid, dataIn, corrEn, outReady, cntClr
// Out: inReady, outValid, dataOut, dataOutWithECC, error,
//      uncorrectable, syndromeOut, corrCnt, uncorrCnt
module g_hamming_decoder_pipe #(
  parameter int p_dataSize = 10,
  parameter int p_lanes = 4,
  parameter int p_zeroWordDetection = 1,
  parameter int p_cntWidth = 16,
  // smallest K with 2**K >= p_dataSize+K+1, by iterating the bound
  localparam int K = $clog2(p_dataSize + 1 +
    $clog2(p_dataSize + 1 + $clog2(p_dataSize + 1))),
  localparam int W = p_dataSize + K + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [p_lanes*W-1:0]       dataIn,
  input  logic                       corrEn,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [p_lanes*p_dataSize-1:0] dataOut,
  output logic [p_lanes*W-1:0]       dataOutWithECC,
  output logic [p_lanes-1:0]         error,
  output logic [p_lanes-1:0]         uncorrectable,
  output logic [p_lanes*K-1:0]       syndromeOut,
  input  logic                       cntClr,
  output logic [p_cntWidth-1:0]      corrCnt,
  output logic [p_cntWidth-1:0]      uncorrCnt
);

  localparam int D = p_dataSize;
  localparam int LW = $clog2(p_lanes + 1);
  localparam int SW = p_cntWidth + LW;
  localparam logic [W-1:0] ONE = W'(1);

  // position (1-based) of the j-th data bit: j-th non-power-of-two
  function automatic int data_pos(input int j);
    int n;
    n = 0;
    data_pos = 0;
    for (int p = 1; p < W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == j) data_pos = p;
        n++;
      end
    end
  endfunction

  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic [p_lanes*W-1:0] s1_cw;
  logic [p_lanes*K-1:0] s1_syn, syn_in;
  logic [p_lanes-1:0] s1_par, par_in;
  logic s1_ce;

  assign s2_adv = !s2_valid || outReady;
  assign s1_adv = !s1_valid || s2_adv;
  assign inReady = s1_adv;
  assign outValid = s2_valid;

  always_comb begin
    syn_in = '0;
    par_in = '0;
    for (int l = 0; l < p_lanes; l++) begin
      par_in[l] = ^dataIn[l*W +: W];
      for (int i = 0; i < K; i++)
        for (int p = 1; p < W; p++)
          if (((p >> i) & 1) == 1)
            syn_in[l*K+i] = syn_in[l*K+i] ^ dataIn[l*W+p-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw <= '0;
      s1_syn <= '0;
      s1_par <= '0;
      s1_ce <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= inValid;
      if (inValid) begin
        s1_cw <= dataIn;
        s1_syn <= syn_in;
        s1_par <= par_in;
        s1_ce <= corrEn;
      end
    end
  end

  logic [p_lanes*D-1:0] dout_d;
  logic [p_lanes*W-1:0] dwe_d;
  logic [p_lanes-1:0] err_d, unc_d;
  logic [LW-1:0] ncorr, nunc;
  logic [W-1:0] cw, cw_o;
  logic [K-1:0] syn;
  logic par, zero, pfix, single, bad, dbl;

  always_comb begin
    dout_d = '0;
    dwe_d = '0;
    err_d = '0;
    unc_d = '0;
    ncorr = '0;
    nunc = '0;
    cw = '0;
    cw_o = '0;
    syn = '0;
    par = 1'b0;
    zero = 1'b0;
    pfix = 1'b0;
    single = 1'b0;
    bad = 1'b0;
    dbl = 1'b0;
    for (int l = 0; l < p_lanes; l++) begin
      cw = s1_cw[l*W +: W];
      syn = s1_syn[l*K +: K];
      par = s1_par[l];
      zero = (p_zeroWordDetection != 0) && (cw == '0);
      pfix = !zero && (syn == '0) && par;
      single = (syn != '0) && par && (int'(syn) <= W - 1);
      bad = (syn != '0) && par && (int'(syn) > W - 1);
      dbl = (syn != '0) && !par;
      cw_o = cw;
      unique case (1'b1)
        zero, bad, dbl: begin
          cw_o = '0;
          err_d[l] = 1'b1;
          unc_d[l] = 1'b1;
          nunc = nunc + LW'(1);
        end
        pfix: begin
          cw_o[W-1] = ~cw[W-1];
          err_d[l] = 1'b1;
          ncorr = ncorr + LW'(1);
        end
        single: begin
          err_d[l] = 1'b1;
          if (s1_ce) begin
            cw_o = cw ^ (ONE << (syn - 1'b1));
            ncorr = ncorr + LW'(1);
          end
        end
        default: ;
      endcase
      for (int j = 0; j < D; j++)
        dout_d[l*D+j] = cw_o[data_pos(j)-1];
      dwe_d[l*W +: W] = cw_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      dataOut <= '0;
      dataOutWithECC <= '0;
      error <= '0;
      uncorrectable <= '0;
      syndromeOut <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        dataOut <= dout_d;
        dataOutWithECC <= dwe_d;
        error <= err_d;
        uncorrectable <= unc_d;
        syndromeOut <= s1_syn;
      end
    end
  end

  logic [SW-1:0] corr_sum, unc_sum;
  logic [p_cntWidth-1:0] corr_nxt, unc_nxt;

  always_comb begin
    corr_sum = {{LW{1'b0}}, corrCnt} + {{p_cntWidth{1'b0}}, ncorr};
    unc_sum = {{LW{1'b0}}, uncorrCnt} + {{p_cntWidth{1'b0}}, nunc};
    corr_nxt = (|corr_sum[SW-1:p_cntWidth]) ? '1
                                             : corr_sum[p_cntWidth-1:0];
    unc_nxt = (|unc_sum[SW-1:p_cntWidth]) ? '1
                                           : unc_sum[p_cntWidth-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corrCnt <= '0;
      uncorrCnt <= '0;
    end else if (cntClr) begin
      corrCnt <= '0;
      uncorrCnt <= '0;
    end else if (s1_valid && s2_adv) begin
      corrCnt <= corr_nxt;
      uncorrCnt <= unc_nxt;
    end
  end

endmodule

// File: tb/tb_g_hamming_decoder_pipe.sv
// Scoreboard bench for g_hamming_decoder_pipe (10 data bits, 4 lanes).
// Two instances share stimulus: 4-bit and 16-bit statistics counters.
module tb_g_hamming_decoder_pipe;
  localparam int D = 10;
  localparam int L = 4;
  localparam int K = 4;
  localparam int W = 15;

  typedef struct {
    logic [L*D-1:0] dout;
    logic [L*W-1:0] dwe;
    logic [L-1:0] err;
    logic [L-1:0] unc;
    logic [L*K-1:0] syn;
    int ncorr;
    int nunc;
    bit clr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, inValid, inReady, corrEn;
  logic outValid, outReady, cntClr;
  logic [L*W-1:0] dataIn, dataOutWithECC;
  logic [L*D-1:0] dataOut;
  logic [L-1:0] error, uncorrectable;
  logic [L*K-1:0] syndromeOut;
  logic [3:0] corrCnt, uncorrCnt;

  logic x_inReady, x_outValid;
  logic [L*W-1:0] x_dwe;
  logic [L*D-1:0] x_dout;
  logic [L-1:0] x_err, x_unc;
  logic [L*K-1:0] x_syn;
  logic [15:0] c16, u16;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_c4 = 0, m_u4 = 0, m_c16 = 0, m_u16 = 0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  g_hamming_decoder_pipe #(
    .p_dataSize(D), .p_lanes(L),
    .p_zeroWordDetection(1), .p_cntWidth(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .inValid(inValid), .inReady(inReady),
    .dataIn(dataIn), .corrEn(corrEn),
    .outValid(outValid), .outReady(outReady),
    .dataOut(dataOut), .dataOutWithECC(dataOutWithECC),
    .error(error), .uncorrectable(uncorrectable),
    .syndromeOut(syndromeOut), .cntClr(cntClr),
    .corrCnt(corrCnt), .uncorrCnt(uncorrCnt)
  );

  g_hamming_decoder_pipe #(
    .p_dataSize(D), .p_lanes(L),
    .p_zeroWordDetection(1), .p_cntWidth(16)
  ) dut16 (
    .clk(clk), .rst_n(rst_n),
    .inValid(inValid), .inReady(x_inReady),
    .dataIn(dataIn), .corrEn(corrEn),
    .outValid(x_outValid), .outReady(outReady),
    .dataOut(x_dout), .dataOutWithECC(x_dwe),
    .error(x_err), .uncorrectable(x_unc),
    .syndromeOut(x_syn), .cntClr(cntClr),
    .corrCnt(c16), .uncorrCnt(u16)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // syndrome as XOR of the 1-based positions of all set bits
  function automatic int pos_xor(input logic [W-1:0] cw);
    int s = 0;
    for (int p = 1; p < W; p++) if (cw[p-1]) s = s ^ p;
    return s;
  endfunction

  function automatic logic [D-1:0] extract(input logic [W-1:0] cw);
    logic [D-1:0] d = '0;
    int j = 0;
    for (int p = 1; p < W; p++)
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p-1];
        j++;
      end
    return d;
  endfunction

  function automatic logic [W-1:0] encode(input logic [D-1:0] d);
    logic [W-1:0] cw = '0;
    int j = 0;
    int s;
    for (int p = 1; p < W; p++)
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[j];
        j++;
      end
    s = pos_xor(cw);
    for (int i = 0; i < K; i++) if (s[i]) cw[(1 << i) - 1] = 1'b1;
    cw[W-1] = ^cw[W-2:0];
    return cw;
  endfunction

  task automatic ref_dec(input logic [W-1:0] cw, input bit ce,
                         output logic [D-1:0] d, output logic [W-1:0] we,
                         output logic er, output logic un,
                         output logic [K-1:0] syn,
                         output int c, output int u);
    int s;
    bit par;
    s = pos_xor(cw);
    par = ^cw;
    syn = s[K-1:0];
    we = cw;
    er = 1'b0;
    un = 1'b0;
    c = 0;
    if (cw == '0) begin
      er = 1'b1; un = 1'b1;
    end else if (s == 0) begin
      if (par) begin
        er = 1'b1; we[W-1] = ~we[W-1]; c = 1;
      end
    end else if (!par || s > W - 1) begin
      er = 1'b1; un = 1'b1;
    end else begin
      er = 1'b1;
      if (ce) begin
        we[s-1] = ~we[s-1]; c = 1;
      end
    end
    if (un) we = '0;
    u = un ? 1 : 0;
    d = extract(we);
  endtask

  function automatic logic [L*W-1:0] beat4(input logic [D-1:0] a,
      input logic [D-1:0] b, input logic [D-1:0] c, input logic [D-1:0] d);
    return {encode(d), encode(c), encode(b), encode(a)};
  endfunction

  function automatic logic [W-1:0] rand_lane();
    logic [W-1:0] cw;
    int r, a, b, c;
    cw = encode(D'($urandom));
    r = $urandom_range(0, 9);
    a = $urandom_range(0, W - 1);
    b = $urandom_range(0, W - 1);
    while (b == a) b = $urandom_range(0, W - 1);
    c = $urandom_range(0, W - 1);
    while (c == a || c == b) c = $urandom_range(0, W - 1);
    if (r >= 4) cw[a] = ~cw[a];
    if (r >= 7) cw[b] = ~cw[b];
    if (r == 8) cw[c] = ~cw[c];
    if (r == 9) cw = '0;
    return cw;
  endfunction

  task automatic issue(input logic [L*W-1:0] din, input bit ce,
                       input bit clr);
    exp_t e;
    logic [D-1:0] d;
    logic [W-1:0] we;
    logic er, un;
    logic [K-1:0] s;
    int c, u, n;
    bit acc;
    e = '{default: 0};
    e.clr = clr;
    for (int l = 0; l < L; l++) begin
      ref_dec(din[l*W +: W], ce, d, we, er, un, s, c, u);
      e.dout[l*D +: D] = d;
      e.dwe[l*W +: W] = we;
      e.err[l] = er;
      e.unc[l] = un;
      e.syn[l*K +: K] = s;
      e.ncorr += c;
      e.nunc += u;
    end
    inValid = 1'b1;
    dataIn = din;
    corrEn = ce;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = inReady;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) q.push_back(e);
    else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got inReady=0 for %0d cycles", n);
    end
    inValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) outReady = 1'($urandom_range(0, 1));
    end
  end

  initial begin : monitor
    exp_t e;
    bit stall;
    logic [L*D-1:0] h_d;
    logic [L*W-1:0] h_w;
    logic [3*L+L*K-1:0] h_f;
    int ec4, eu4, ec16, eu16;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        m_c4 = 0; m_u4 = 0; m_c16 = 0; m_u16 = 0;
        continue;
      end
      chk("in_ready", 64'(inReady), 64'(outReady || q.size() < 2));
      if (stall) begin
        chk("hold_valid", 64'(outValid), 64'(1));
        chk("hold_data", 64'(dataOut), 64'(h_d));
        chk("hold_ecc", 64'(dataOutWithECC), 64'(h_w));
        chk("hold_flags", 64'({error, uncorrectable, syndromeOut}),
            64'(h_f));
      end
      stall = 1'b0;
      if (outValid && q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_beat: got outValid=1 expected no beat");
      end else if (outValid) begin
        e = q[0];
        if (!outReady) begin
          stall = 1'b1;
          h_d = dataOut;
          h_w = dataOutWithECC;
          h_f = {error, uncorrectable, syndromeOut};
        end else begin
          chk("data_out", 64'(dataOut), 64'(e.dout));
          chk("data_ecc", 64'(dataOutWithECC), 64'(e.dwe));
          chk("error", 64'(error), 64'(e.err));
          chk("uncorrectable", 64'(uncorrectable), 64'(e.unc));
          chk("syndrome", 64'(syndromeOut), 64'(e.syn));
          if (e.clr) begin
            ec4 = 0; eu4 = 0; ec16 = 0; eu16 = 0;
          end else begin
            ec4 = sat(m_c4 + e.ncorr, 15);
            eu4 = sat(m_u4 + e.nunc, 15);
            ec16 = sat(m_c16 + e.ncorr, 65535);
            eu16 = sat(m_u16 + e.nunc, 65535);
          end
          chk("corr_cnt4", 64'(corrCnt), 64'(ec4));
          chk("uncorr_cnt4", 64'(uncorrCnt), 64'(eu4));
          chk("corr_cnt16", 64'(c16), 64'(ec16));
          chk("uncorr_cnt16", 64'(u16), 64'(eu16));
          m_c4 = ec4; m_u4 = eu4; m_c16 = ec16; m_u16 = eu16;
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [L*W-1:0] b, b1;
    int pat[4] = '{1, 0, 0, 1};
    rst_n = 1'b0;
    inValid = 1'b0;
    dataIn = '0;
    corrEn = 1'b0;
    outReady = 1'b1;
    cntClr = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(outValid), 64'(0));
    chk("rst_corr", 64'(corrCnt), 64'(0));
    chk("rst_uncorr", 64'(uncorrCnt), 64'(0));
    chk("rst_data", 64'(dataOut), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(inReady), 64'(1));
    @(posedge clk);
    #1;

    b = beat4(10'h2A5, 10'h155, 10'h3FF, 10'h001);
    issue(b, 1'b1, 1'b0);
    @(negedge clk);
    chk("latency_c1", 64'(outValid), 64'(0));
    @(negedge clk);
    chk("latency_c2", 64'(outValid), 64'(1));
    drain();
    chk("clean_corr", 64'(corrCnt), 64'(0));
    chk("clean_uncorr", 64'(uncorrCnt), 64'(0));

    b1 = b;
    b1[6] = ~b1[6];
    issue(b1, 1'b1, 1'b0);
    issue(b1, 1'b0, 1'b0);
    b1 = b;
    b1[2*W+2] = ~b1[2*W+2];
    b1[2*W+5] = ~b1[2*W+5];
    issue(b1, 1'b1, 1'b0);
    b1 = b;
    b1[3*W +: W] = '0;
    issue(b1, 1'b1, 1'b0);
    b1 = b;
    b1[W+14] = ~b1[W+14];
    issue(b1, 1'b1, 1'b0);
    drain();
    chk("dir_corr", 64'(corrCnt), 64'(2));
    chk("dir_uncorr", 64'(uncorrCnt), 64'(2));

    fork
      begin
        for (int i = 0; i < 4; i++)
          issue(beat4(D'($urandom), D'($urandom), D'($urandom),
                      D'($urandom)), 1'b1, 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          outReady = 1'(pat[i]);
          @(posedge clk);
          #1;
        end
        outReady = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 5; i++) begin
      b1 = beat4(D'($urandom), D'($urandom), D'($urandom), D'($urandom));
      for (int l = 0; l < L; l++)
        b1[l*W + $urandom_range(0, W - 2)] ^= 1'b1;
      issue(b1, 1'b1, 1'b0);
    end
    drain();
    chk("sat_corr4", 64'(corrCnt), 64'(15));
    chk("sat_corr16", 64'(c16), 64'(22));

    b1 = b;
    b1[3] = ~b1[3];
    issue(b1, 1'b1, 1'b1);
    cntClr = 1'b1;
    @(posedge clk);
    #1 cntClr = 1'b0;
    drain();
    chk("clr_corr4", 64'(corrCnt), 64'(0));
    chk("clr_corr16", 64'(c16), 64'(0));
    chk("clr_uncorr16", 64'(u16), 64'(0));

    rand_ready = 1'b1;
    repeat (300) begin
      for (int l = 0; l < L; l++) b1[l*W +: W] = rand_lane();
      issue(b1, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 outReady = 1'b1;
    drain();

    outReady = 1'b0;
    b1 = b;
    b1[0] = ~b1[0];
    b1[2*W+1] = ~b1[2*W+1];
    b1[2*W+9] = ~b1[2*W+9];
    issue(b1, 1'b1, 1'b0);
    issue(b, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", 64'(outValid), 64'(0));
    chk("mid_rst_corr", 64'(corrCnt), 64'(0));
    chk("mid_rst_uncorr", 64'(uncorrCnt), 64'(0));
    chk("mid_rst_corr16", 64'(c16), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    outReady = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(outValid), 64'(0));
      chk("post_rst_ready", 64'(inReady), 64'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/g_hamming_decoder_pipe.md
Name: g_hamming_decoder_pipe

Overview:
- Multi-lane, two-stage pipelined SECDED Hamming decoder with valid/ready flow control.
- Next generation of the combinational Hamming decoder: same codeword layout and classification, plus lanes, registered stages, a detect-only mode and saturating error statistics.
- Sits between the ECC-protected storage/link and the hash pipeline.
- Codeword width W = p_dataSize + K + 1, with K = G_RD_PROJ_functions::ECC_bitsQnty(p_dataSize).
- Codeword layout:
  - Position p (1..W-1) is at bit p-1.
  - Check bits sit at power-of-two positions.
  - Overall parity bit is at bit W-1.

Parameters:
p_dataSize, 10, data bits per lane
p_lanes, 4, independent codewords decoded per beat
p_zeroWordDetection, 1, 1: an all-zero codeword is flagged uncorrectable
p_cntWidth, 16, width of each saturating statistics counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inValid  in  1  input beat valid
inReady  out  1  block can accept a beat
dataIn  in  p_lanes*W  codewords; lane L occupies bits [L*W +: W]
corrEn  in  1  1: correct single errors; 0: detect only. Sampled with the beat.
outValid  out  1  output beat valid
outReady  in  1  downstream accepts the beat
dataOut  out  p_lanes*p_dataSize  extracted data per lane
dataOutWithECC  out  p_lanes*W  corrected codeword per lane
error  out  p_lanes  per-lane error flag
uncorrectable  out  p_lanes  per-lane uncorrectable flag
syndromeOut  out  p_lanes*K  per-lane raw syndrome, for debug
cntClr  in  1  synchronous clear of both counters
corrCnt  out  p_cntWidth  count of lanes with a corrected error
uncorrCnt  out  p_cntWidth  count of lanes flagged uncorrectable

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both stage valid flags are 0, so outValid=0.
  - All data, status and syndrome registers are 0.
  - Both counters are 0.
  - inReady=1 as soon as reset is released.
  - Reset mid-operation discards in-flight beats; no partial counter update occurs.
- Pipeline:
  - S1 registers the codeword, syndrome (K bits), overall parity (XOR of all W bits) and corrEn.
  - S2 registers the corrected outputs and flags.
  - Latency is exactly 2 cycles from the accepting edge (inValid&inReady) to outValid, when there are no stalls.
  - Throughput is one beat per cycle.
- Handshake:
  - s2Adv = !s2Valid | outReady
  - s1Adv = !s1Valid | s2Adv
  - inReady = s1Adv (combinational from outReady; no skid buffer)
  - While outValid=1 and outReady=0, all output ports hold stable.
  - No beat is dropped or duplicated.
- Per-lane syndrome: bit i = XOR of dataIn[p-1] over all p in 1..W-1 with bit i of p set.
- Per-lane classification, in priority order:
  1. Zero word: p_zeroWordDetection=1 and codeword=0 -> error=1, uncorrectable=1, dataOut=0, dataOutWithECC=0.
  2. syn=0, par=0 -> clean; error=0; data extracted unchanged.
  3. syn=0, par=1 -> overall-parity-bit error; error=1, uncorrectable=0; dataOut extracted unchanged; dataOutWithECC has bit W-1 inverted. Counts as corrected.
  4. syn!=0, par=1, syn<=W-1 -> single error at bit syn-1; error=1, uncorrectable=0.
     - corrEn=1: flip that bit, then extract.
     - corrEn=0: pass through uncorrected; not counted.
  5. syn!=0, par=1, syn>W-1 (impossible position) -> uncorrectable=1; outputs 0.
  6. syn!=0, par=0 -> double error; uncorrectable=1; dataOut=0, dataOutWithECC=0.
- Extraction: non-power-of-two positions, ascending, fill dataOut LSB first.
- Counters:
  - Update when a beat enters S2.
  - Each adds the number of lanes in its class: corrCnt counts classes 3 and 4 with corrEn=1; uncorrCnt counts classes 1, 5 and 6.
  - Saturate at all-ones, with no wrap.
  - cntClr takes priority over a simultaneous increment; the result is 0 on that edge.

Test Plan:
- p_dataSize=10 (K=4, W=15), p_lanes=4. Clean encoded words, 0x2A5/0x155/0x3FF/0x001, with outReady=1 → each beat appears 2 cycles later, unchanged; error=0; counters stay 0.
- Lane 0 codeword bit 6 flipped, corrEn=1 → syndromeOut lane 0 = 7; data corrected; error[0]=1; corrCnt=1.
- Same beat with corrEn=0 → error[0]=1; dataOut equals the raw extraction; corrCnt unchanged.
- Lane 2 codeword with bits 2 and 5 flipped → uncorrectable[2]=1; lane 2 outputs 0; uncorrCnt=1. Separately, an all-zero codeword on lane 3 → uncorrectable[3]=1; uncorrCnt increments.
- Lane 1 codeword with only bit 14 flipped → error[1]=1; dataOut correct; dataOutWithECC bit 14 restored.
- Back-to-back beats with outReady toggling 1,0,0,1 → outputs hold during stalls; inReady=0 while both stages are full; all beats delivered in order.
- p_cntWidth=4 with 20 single-error lanes injected → corrCnt saturates at 15.
- cntClr asserted in the same cycle as an increment → corrCnt=0.
- rst_n asserted mid-stream → outValid=0 immediately; counters read 0.
